// File: rtl/fifo_ext_mem_pkg.sv
// ============================================================================
// Module : fifo_ext_mem_pkg
// Brief  : Shared constants and helpers for the external-memory FIFO controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_ext_mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Wraps at depth-1 so non-power-of-two depths stay inside the memory range.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_lat_pipe.sv
// ============================================================================
// Module : fifo_rd_lat_pipe
// Brief  : Read-latency valid shift register plus registered dout capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_lat_pipe
    import fifo_ext_mem_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dvalid_o
);

    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] dout_q;
    logic             dvalid_q;

    if (LAT == 1) begin : g_lat_one
        always_ff @(posedge clk) begin
            if (rst) vld_q <= '0;
            else     vld_q <= re_i;
        end
    end else begin : g_lat_multi
        always_ff @(posedge clk) begin
            if (rst) vld_q <= '0;
            else     vld_q <= {vld_q[LAT-2:0], re_i};
        end
    end

    // mem_q is only meaningful while the oldest stage is set; dout holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= vld_q[LAT-1];
            if (vld_q[LAT-1]) dout_q <= q_i;
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

endmodule

`default_nettype wire

// File: rtl/fifo_ext_mem_ctrl.sv
// ============================================================================
// Module : fifo_ext_mem_ctrl
// Brief  : Single-clock FIFO controller driving an external dual-port memory.
//          Optional overflow/underflow pulses: FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ext_mem_ctrl
    import fifo_ext_mem_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 1,
    parameter int AFULL_TH  = 1020,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  din,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  dout,
    output logic              dvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_re,
    input  logic [WIDTH-1:0]  mem_q
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int CNT_W = cnt_width(ADDR_W);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              wr_acc, rd_acc;

    // A write into a full FIFO is legal when a read frees the slot it targets.
    always_comb begin
        rd_acc  = rd_en & ~empty_q;
        wr_acc  = wr_en & (~full_q | rd_acc);
        wptr_d  = wr_acc ? ADDR_W'(ptr_inc(32'(wptr_q), 32'(DEPTH))) : wptr_q;
        rptr_d  = rd_acc ? ADDR_W'(ptr_inc(32'(rptr_q), 32'(DEPTH))) : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= CNT_W'(AFULL_TH));
            aempty_q <= (count_d <= CNT_W'(AEMPTY_TH));
        end
    end

    assign mem_we       = wr_acc;
    assign mem_waddr    = wptr_q;
    assign mem_wdata    = din;
    assign mem_re       = rd_acc;
    assign mem_raddr    = rptr_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

    fifo_rd_lat_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .re_i     (rd_acc),
        .q_i      (mem_q),
        .dout_o   (dout),
        .dvalid_o (dvalid)
    );

`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_en & full_q & ~rd_acc;
            underflow_q <= rd_en & empty_q;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_ext_mem_ctrl.sv
// ============================================================================
// Module : tb_fifo_ext_mem_ctrl
// Brief  : Bench for fifo_ext_mem_ctrl: a 1024-deep/RD_LAT=1 and a 6-deep/RD_LAT=2
//          instance share stimulus and are checked against queue-based models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_ext_mem_ctrl;

    typedef struct {
        int          due;
        logic [17:0] d;
    } rd_t;

    localparam int DEP [2] = '{1024, 6};
    localparam int LAT [2] = '{1, 2};
    localparam int AFT [2] = '{1020, 5};
    localparam int AET [2] = '{4, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [17:0] din = '0;

    always #5 clk = ~clk;

    logic [17:0] b_dout, b_wd, b_q;
    logic        b_dv, b_full, b_empty, b_af, b_ae, b_we, b_re;
    logic [10:0] b_cnt;
    logic [9:0]  b_wa, b_ra;
    logic [17:0] s_dout, s_wd, s_q1, s_q2;
    logic        s_dv, s_full, s_empty, s_af, s_ae, s_we, s_re;
    logic [3:0]  s_cnt;
    logic [2:0]  s_wa, s_ra;
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
    logic        b_ov, b_uf, s_ov, s_uf;
`endif

    fifo_ext_mem_ctrl u_big (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(b_dout), .dvalid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .mem_waddr(b_wa), .mem_wdata(b_wd), .mem_we(b_we),
        .mem_raddr(b_ra), .mem_re(b_re), .mem_q(b_q)
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
        , .overflow(b_ov), .underflow(b_uf)
`endif
    );

    fifo_ext_mem_ctrl #(
        .WIDTH(18), .ADDR_W(3), .DEPTH(6), .RD_LAT(2), .AFULL_TH(5), .AEMPTY_TH(1)
    ) u_small (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .dvalid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .mem_waddr(s_wa), .mem_wdata(s_wd), .mem_we(s_we),
        .mem_raddr(s_ra), .mem_re(s_re), .mem_q(s_q2)
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
        , .overflow(s_ov), .underflow(s_uf)
`endif
    );

    // Read-first external memories with 1- and 2-cycle read latency.
    logic [17:0] bmem [0:1023];
    logic [17:0] smem [0:7];
    always @(posedge clk) begin
        if (b_we) bmem[b_wa] <= b_wd;
        if (b_re) b_q <= bmem[b_ra];
        if (s_we) smem[s_wa] <= s_wd;
        if (s_re) s_q1 <= smem[s_ra];
        s_q2 <= s_q1;
    end

    logic [17:0] o_dout [2];
    logic [17:0] o_wd   [2];
    logic        o_dv [2], o_full [2], o_empty [2], o_af [2], o_ae [2], o_we [2], o_re [2];
    logic [31:0] o_cnt [2], o_wa [2], o_ra [2];
    assign o_dout[0] = b_dout;  assign o_dout[1] = s_dout;
    assign o_wd[0]   = b_wd;    assign o_wd[1]   = s_wd;
    assign o_dv[0]   = b_dv;    assign o_dv[1]   = s_dv;
    assign o_full[0] = b_full;  assign o_full[1] = s_full;
    assign o_empty[0]= b_empty; assign o_empty[1]= s_empty;
    assign o_af[0]   = b_af;    assign o_af[1]   = s_af;
    assign o_ae[0]   = b_ae;    assign o_ae[1]   = s_ae;
    assign o_we[0]   = b_we;    assign o_we[1]   = s_we;
    assign o_re[0]   = b_re;    assign o_re[1]   = s_re;
    assign o_cnt[0]  = 32'(b_cnt); assign o_cnt[1] = 32'(s_cnt);
    assign o_wa[0]   = 32'(b_wa);  assign o_wa[1]  = 32'(s_wa);
    assign o_ra[0]   = 32'(b_ra);  assign o_ra[1]  = 32'(s_ra);
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
    logic o_ov [2], o_uf [2];
    assign o_ov[0] = b_ov; assign o_ov[1] = s_ov;
    assign o_uf[0] = b_uf; assign o_uf[1] = s_uf;
`endif

    // Reference model: occupancy, pointer positions, stored words, scheduled outputs.
    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          mcnt [2];
    int          mwp  [2];
    int          mrp  [2];
    logic [17:0] mlast [2];
    logic [17:0] fq0 [$];
    logic [17:0] fq1 [$];
    rd_t         pq0 [$];
    rd_t         pq1 [$];

    task automatic step(input bit we, input bit re, input logic [17:0] d);
        bit  rok [2];
        bit  wok [2];
        bit  ov  [2];
        bit  uf  [2];
        bit  have;
        rd_t e;
        wr_en = we; rd_en = re; din = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            rok[i] = re && (mcnt[i] > 0);
            wok[i] = we && ((mcnt[i] < DEP[i]) || rok[i]);
            ov[i]  = we && (mcnt[i] == DEP[i]) && !rok[i];
            uf[i]  = re && (mcnt[i] == 0);
            nchk++;
            if (o_we[i] !== wok[i] || o_re[i] !== rok[i]) begin
                nerr++;
                $display("FAIL mem_en dut%0d: we=%b re=%b required we=%b re=%b", i, o_we[i], o_re[i], wok[i], rok[i]);
            end
            if (wok[i]) begin
                nchk++;
                if (o_wa[i] !== 32'(mwp[i]) || o_wd[i] !== d) begin
                    nerr++;
                    $display("FAIL mem_wr dut%0d: waddr=%0d wdata=%h required waddr=%0d wdata=%h", i, o_wa[i], o_wd[i], mwp[i], d);
                end
            end
            if (rok[i]) begin
                nchk++;
                if (o_ra[i] !== 32'(mrp[i])) begin
                    nerr++;
                    $display("FAIL mem_raddr dut%0d: got %0d required %0d", i, o_ra[i], mrp[i]);
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rok[i]) begin
                e.due = cyc + LAT[i] + 1;
                if (i == 0) begin e.d = fq0.pop_front(); pq0.push_back(e); end
                else        begin e.d = fq1.pop_front(); pq1.push_back(e); end
                mrp[i]  = (mrp[i] + 1) % DEP[i];
                mcnt[i] = mcnt[i] - 1;
            end
            if (wok[i]) begin
                if (i == 0) fq0.push_back(d);
                else        fq1.push_back(d);
                mwp[i]  = (mwp[i] + 1) % DEP[i];
                mcnt[i] = mcnt[i] + 1;
            end
        end
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nchk++;
            if (o_cnt[i] !== 32'(mcnt[i]) || o_full[i] !== (mcnt[i] == DEP[i]) ||
                o_empty[i] !== (mcnt[i] == 0) || o_af[i] !== (mcnt[i] >= AFT[i]) ||
                o_ae[i] !== (mcnt[i] <= AET[i])) begin
                nerr++;
                $display("FAIL status dut%0d: count=%0d full=%b empty=%b af=%b ae=%b required count=%0d", i,
                         o_cnt[i], o_full[i], o_empty[i], o_af[i], o_ae[i], mcnt[i]);
            end
            have = 1'b0;
            if (i == 0 && pq0.size() > 0 && pq0[0].due == cyc) begin have = 1'b1; e = pq0.pop_front(); end
            if (i == 1 && pq1.size() > 0 && pq1[0].due == cyc) begin have = 1'b1; e = pq1.pop_front(); end
            if (have) mlast[i] = e.d;
            nchk++;
            if (o_dv[i] !== have || o_dout[i] !== mlast[i]) begin
                nerr++;
                $display("FAIL read_data dut%0d: dvalid=%b dout=%h required dvalid=%b dout=%h", i, o_dv[i], o_dout[i], have, mlast[i]);
            end
`ifdef FIFO_EXT_MEM_CTRL_ERR_FLAGS_EN
            nchk++;
            if (o_ov[i] !== ov[i] || o_uf[i] !== uf[i]) begin
                nerr++;
                $display("FAIL err_flags dut%0d: overflow=%b underflow=%b required %b %b", i, o_ov[i], o_uf[i], ov[i], uf[i]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (o_dv[i] !== 1'b0) begin
                    nerr++;
                    $display("FAIL dvalid_in_reset dut%0d: got %b required 0", i, o_dv[i]);
                end
            end
        end
        rst = 1'b0;
        fq0.delete(); fq1.delete(); pq0.delete(); pq1.delete();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mwp[i] = 0; mrp[i] = 0; mlast[i] = '0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            nchk++;
            if (o_cnt[i] !== 32'd0 || o_empty[i] !== 1'b1 || o_ae[i] !== 1'b1 || o_full[i] !== 1'b0 ||
                o_af[i] !== 1'b0 || o_dv[i] !== 1'b0 || o_dout[i] !== 18'd0 || o_we[i] !== 1'b0 || o_re[i] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state dut%0d: count=%0d empty=%b ae=%b full=%b af=%b dvalid=%b dout=%h we=%b re=%b required 0 1 1 0 0 0 0 0 0",
                         i, o_cnt[i], o_empty[i], o_ae[i], o_full[i], o_af[i], o_dv[i], o_dout[i], o_we[i], o_re[i]);
            end
        end
    endtask

    task automatic check_drained();
        nchk++;
        if (pq0.size() != 0 || pq1.size() != 0) begin
            nerr++;
            $display("FAIL missing_dvalid: outstanding big=%0d small=%0d required 0 0", pq0.size(), pq1.size());
        end
    endtask

    task automatic test_fill_drain();
        test_reset();
        for (int i = 0; i < 1024; i++) step(1'b1, 1'b0, 18'(i));
        nchk++;
        if (b_full !== 1'b1 || b_af !== 1'b1) begin
            nerr++;
            $display("FAIL fill_full: full=%b almost_full=%b required 1 1", b_full, b_af);
        end
        for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 18'd0);
        repeat (4) step(1'b0, 1'b0, 18'd0);
        check_drained();
    endtask

    task automatic test_wrap();
        test_reset();
        for (int r = 0; r < 2; r++) begin
            repeat (4) step(1'b1, 1'b0, 18'($urandom));
            repeat (4) step(1'b0, 1'b1, 18'd0);
        end
        repeat (4) step(1'b0, 1'b0, 18'd0);
        check_drained();
    endtask

    task automatic test_simul_boundary();
        test_reset();
        step(1'b1, 1'b1, 18'($urandom));
        repeat (1023) step(1'b1, 1'b0, 18'($urandom));
        repeat (3) step(1'b1, 1'b1, 18'($urandom));
        repeat (3) step(1'b1, 1'b0, 18'($urandom));
        repeat (1030) step(1'b0, 1'b1, 18'd0);
        repeat (4) step(1'b0, 1'b0, 18'd0);
        check_drained();
    endtask

    task automatic test_reset_mid_read();
        test_reset();
        step(1'b1, 1'b0, 18'h2aaaa);
        step(1'b1, 1'b0, 18'h15555);
        step(1'b0, 1'b1, 18'd0);
        test_reset();
        repeat (5) step(1'b0, 1'b0, 18'd0);
    endtask

    task automatic test_random();
        int pw;
        test_reset();
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph == 0) ? 80 : (ph == 2) ? 20 : 50;
            repeat (700) step($urandom_range(99) < 32'(pw), $urandom_range(99) >= 32'(pw),
                              18'($urandom));
        end
        repeat (1030) step(1'b0, 1'b1, 18'd0);
        repeat (4) step(1'b0, 1'b0, 18'd0);
        check_drained();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simul_boundary();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

`default_nettype wire
